// File: rtl/alu_operand_sel.sv
// alu_operand_sel: registered ALU source-B operand select with a 2-entry valid/ready skid stage.
// Optional err_count/err_clr ports are enabled by defining ALU_OPERAND_SEL_ERRCNT_EN.
module alu_operand_sel #(
    parameter int WIDTH     = 32,
    parameter int NUM_IN    = 4,
    parameter int SEL_W     = 2,
    parameter int CONST_IDX = 1,
    parameter int CONST_VAL = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
`ifdef ALU_OPERAND_SEL_ERRCNT_EN
    ,
    input  logic                    err_clr,
    output logic [7:0]              err_count
`endif
);
    logic [WIDTH-1:0] chan [2**SEL_W];
    logic [WIDTH-1:0] sel_data, skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             sel_err, skid_err, skid_full;

    // Unused select codes map to zero so the lookup never indexes past in_data.
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_chan
        if (k == CONST_IDX) begin : g_const
            assign chan[k] = WIDTH'(CONST_VAL);
        end else if (k < NUM_IN) begin : g_in
            assign chan[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_zero
            assign chan[k] = '0;
        end
    end

    if (CONST_IDX < NUM_IN) begin : g_ign
        logic unused_const;
        assign unused_const = ^in_data[CONST_IDX*WIDTH +: WIDTH];
    end

    assign sel_err  = {1'b0, in_sel} >= (SEL_W+1)'(NUM_IN);
    assign sel_data = chan[in_sel];
    assign in_ready = !skid_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_err   <= 1'b0;
            skid_full <= 1'b0;
            skid_data <= '0;
            skid_sel  <= '0;
            skid_err  <= 1'b0;
        end else if (skid_full) begin
            if (out_ready) begin
                out_data  <= skid_data;
                out_sel   <= skid_sel;
                out_err   <= skid_err;
                skid_full <= 1'b0;
            end
        end else if (in_valid) begin
            if (!out_valid || out_ready) begin
                out_data  <= sel_data;
                out_sel   <= in_sel;
                out_err   <= sel_err;
                out_valid <= 1'b1;
            end else begin
                skid_data <= sel_data;
                skid_sel  <= in_sel;
                skid_err  <= sel_err;
                skid_full <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef ALU_OPERAND_SEL_ERRCNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_count <= '0;
        else if (err_clr)
            err_count <= '0;
        else if (in_valid && in_ready && sel_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_alu_operand_sel.sv
// tb_alu_operand_sel: scoreboard bench driving a default instance and a NUM_IN=3 instance in parallel.
// Counter checks are compiled when ALU_OPERAND_SEL_ERRCNT_EN is defined.
module tb_alu_operand_sel;
    logic         clk = 0, reset_n = 0;
    logic [127:0] in_data = '0;
    logic [1:0]   in_sel = '0;
    logic         in_valid = 0, out_ready = 0;
    logic         in_ready4, out_err4, out_valid4, in_ready3, out_err3, out_valid3;
    logic [31:0]  out_data4, out_data3;
    logic [1:0]   out_sel4, out_sel3;
    logic [34:0]  q4[$], q3[$];
    int           total = 0, bad = 0;
`ifdef ALU_OPERAND_SEL_ERRCNT_EN
    logic         err_clr = 0;
    logic [7:0]   err_count4, err_count3;
`endif

    always #5 clk = ~clk;

    alu_operand_sel dut4 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
        .out_sel(out_sel4), .out_err(out_err4), .out_valid(out_valid4),
        .out_ready(out_ready)
`ifdef ALU_OPERAND_SEL_ERRCNT_EN
        , .err_clr(err_clr), .err_count(err_count4)
`endif
    );

    alu_operand_sel #(.NUM_IN(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .in_data(in_data[95:0]), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready3), .out_data(out_data3),
        .out_sel(out_sel3), .out_err(out_err3), .out_valid(out_valid3),
        .out_ready(out_ready)
`ifdef ALU_OPERAND_SEL_ERRCNT_EN
        , .err_clr(err_clr), .err_count(err_count3)
`endif
    );

    function automatic logic [34:0] expect_beat(input logic [1:0] s, input logic [127:0] d, input int n);
        logic [31:0] v;
        if (s == 2'd1) v = 32'd4;
        else if (int'(s) < n) v = d[s*32 +: 32];
        else v = 32'd0;
        return {int'(s) >= n, s, v};
    endfunction

    // Scoreboard: beats are pushed on acceptance and popped on each drain.
    always @(negedge clk) begin
        logic [34:0] e;
        if (!reset_n) begin
            q4.delete();
            q3.delete();
        end else begin
            if (out_valid4 && out_ready) begin
                total++;
                if (q4.size() == 0) begin
                    bad++;
                    $display("FAIL sb4: unexpected beat data=%h", out_data4);
                end else begin
                    e = q4.pop_front();
                    if ({out_err4, out_sel4, out_data4} !== e) begin
                        bad++;
                        $display("FAIL sb4: got=%h want=%h", {out_err4, out_sel4, out_data4}, e);
                    end
                end
            end
            if (out_valid3 && out_ready) begin
                total++;
                if (q3.size() == 0) begin
                    bad++;
                    $display("FAIL sb3: unexpected beat data=%h", out_data3);
                end else begin
                    e = q3.pop_front();
                    if ({out_err3, out_sel3, out_data3} !== e) begin
                        bad++;
                        $display("FAIL sb3: got=%h want=%h", {out_err3, out_sel3, out_data3}, e);
                    end
                end
            end
            if (in_valid && in_ready4) q4.push_back(expect_beat(in_sel, in_data, 4));
            if (in_valid && in_ready3) q3.push_back(expect_beat(in_sel, in_data, 3));
        end
    end

    task automatic do_reset();
        in_valid = 0;
        out_ready = 0;
        reset_n = 0;
        @(posedge clk); #1;
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({out_valid4, out_data4, out_sel4, out_err4, in_ready4} !== {1'b0, 32'd0, 2'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset4: v=%b d=%h s=%0d e=%b r=%b", out_valid4, out_data4, out_sel4, out_err4, in_ready4);
        end
        total++;
        if ({out_valid3, out_data3, in_ready3} !== {1'b0, 32'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset3: v=%b d=%h r=%b", out_valid3, out_data3, in_ready3);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (out_valid4 !== 1'b0 || out_data4 !== 32'd0) begin
            bad++;
            $display("FAIL idle_hold: v=%b d=%h want v=0 d=0", out_valid4, out_data4);
        end
    endtask

    task automatic test_select();
        logic [31:0] want [4] = '{32'h11, 32'h4, 32'hFFFF_FFF0, 32'h40};
        do_reset();
        out_ready = 1;
        in_data = {32'h0000_0040, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 32'h0000_0011};
        in_valid = 1;
        for (int i = 0; i < 5; i++) begin
            in_sel = 2'(i);
            if (i == 4) in_valid = 0;
            @(negedge clk);
            if (i > 0) begin
                total++;
                if (out_valid4 !== 1'b1 || out_data4 !== want[i-1] || out_err4 !== 1'b0) begin
                    bad++;
                    $display("FAIL select%0d: v=%b d=%h e=%b want v=1 d=%h e=0", i-1, out_valid4, out_data4, out_err4, want[i-1]);
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_out_of_range();
        do_reset();
        out_ready = 1;
        in_sel = 2'd3;
        in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        total++;
        if ({out_valid3, out_err3, out_sel3, out_data3} !== {1'b1, 1'b1, 2'd3, 32'd0}) begin
            bad++;
            $display("FAIL oor3: v=%b e=%b s=%0d d=%h want v=1 e=1 s=3 d=0", out_valid3, out_err3, out_sel3, out_data3);
        end
        total++;
        if (out_err4 !== 1'b0 || out_data4 !== in_data[127:96]) begin
            bad++;
            $display("FAIL inrange4: e=%b d=%h want e=0 d=%h", out_err4, out_data4, in_data[127:96]);
        end
`ifdef ALU_OPERAND_SEL_ERRCNT_EN
        total++;
        if (err_count3 !== 8'd1 || err_count4 !== 8'd0) begin
            bad++;
            $display("FAIL errcnt_one: c3=%0d c4=%0d want 1 0", err_count3, err_count4);
        end
`endif
    endtask

    task automatic test_backpressure();
        do_reset();
        in_sel = 2'd0;
        in_data[31:0] = 32'hA;
        in_valid = 1;
        @(posedge clk); #1;
        in_data[31:0] = 32'hB;
        @(posedge clk); #1;
        in_valid = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++;
            if (out_valid4 !== 1'b1 || out_data4 !== 32'hA || in_ready4 !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: v=%b d=%h r=%b want v=1 d=a r=0", i, out_valid4, out_data4, in_ready4);
            end
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_valid4 !== 1'b1 || out_data4 !== 32'hB || in_ready4 !== 1'b1) begin
            bad++;
            $display("FAIL skid_move: v=%b d=%h r=%b want v=1 d=b r=1", out_valid4, out_data4, in_ready4);
        end
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (out_valid4 !== 1'b0 || q4.size() != 0) begin
            bad++;
            $display("FAIL drained: v=%b left=%0d want v=0 left=0", out_valid4, q4.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        in_sel = 2'd2;
        in_valid = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        total++;
        if (in_ready4 !== 1'b0) begin
            bad++;
            $display("FAIL skid_full: r=%b want r=0", in_ready4);
        end
        #2 reset_n = 0;
        #1;
        total++;
        if ({out_valid4, out_data4, in_ready4, out_valid3, in_ready3} !== {1'b0, 32'd0, 1'b1, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL async_reset: v=%b d=%h r=%b v3=%b r3=%b want 0 0 1 0 1", out_valid4, out_data4, in_ready4, out_valid3, in_ready3);
        end
        @(negedge clk);
        @(posedge clk); #1;
        reset_n = 1;
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if (out_valid4 !== 1'b0 || out_valid3 !== 1'b0) begin
                bad++;
                $display("FAIL stale%0d: v4=%b v3=%b want 0 0", i, out_valid4, out_valid3);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_sel = 2'($urandom_range(0, 3));
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 0;
        out_ready = 1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (q4.size() != 0 || q3.size() != 0 || out_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL lost_beats: left4=%0d left3=%0d v=%b want 0 0 0", q4.size(), q3.size(), out_valid4);
        end
    endtask

`ifdef ALU_OPERAND_SEL_ERRCNT_EN
    task automatic test_saturation();
        do_reset();
        out_ready = 1;
        in_sel = 2'd3;
        in_valid = 1;
        repeat (300) @(posedge clk);
        #1;
        @(negedge clk);
        total++;
        if (err_count3 !== 8'd255 || err_count4 !== 8'd0) begin
            bad++;
            $display("FAIL saturate: c3=%0d c4=%0d want 255 0", err_count3, err_count4);
        end
        @(posedge clk); #1;
        err_clr = 1;
        @(posedge clk); #1;
        err_clr = 0;
        in_valid = 0;
        @(negedge clk);
        total++;
        if (err_count3 !== 8'd0) begin
            bad++;
            $display("FAIL clr_wins: c3=%0d want 0", err_count3);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_select();
        test_out_of_range();
        test_backpressure();
        test_async_reset();
        test_back_to_back();
`ifdef ALU_OPERAND_SEL_ERRCNT_EN
        test_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_operand_sel.md
Name: alu_operand_sel

Overview:
- Parametrised, registered successor to the ALU source-B operand mux of the multi-cycle datapath.
- Selects one of NUM_IN operand channels. One channel index is a built-in constant (PC increment).
- Delivers the selected operand through a 2-entry valid/ready skid stage, so the control FSM can stall the ALU without losing an operand.
- Flags out-of-range selects instead of silently producing zero.

Parameters:
- WIDTH, 32, operand width in bits.
- NUM_IN, 4, number of selectable channels (2..8).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- CONST_IDX, 1, channel index replaced by CONST_VAL; in_data slice at this index is ignored.
- CONST_VAL, 4, constant driven on channel CONST_IDX, zero-extended to WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- in_data, input, NUM_IN*WIDTH, packed channels; channel k = in_data[k*WIDTH +: WIDTH].
- in_sel, input, SEL_W, channel select (the ALUSrcB code).
- in_valid, input, 1, upstream beat valid.
- in_ready, output, 1, block can accept a beat this cycle.
- out_data, output, WIDTH, selected operand.
- out_sel, output, SEL_W, select code that produced out_data.
- out_err, output, 1, in_sel was >= NUM_IN for this beat.
- out_valid, output, 1, out_data/out_sel/out_err valid.
- out_ready, input, 1, ALU side accepts the beat.

Behaviour:
- Reset (reset_n low, async): out_valid=0, out_data=0, out_sel=0, out_err=0, skid entry empty, in_ready=1. Outputs hold these values until the first accepted beat.
- Accept rule: a beat transfers in when in_valid && in_ready at a rising edge. It transfers out when out_valid && out_ready.
- Selection, combinational on the input side:
  - in_sel == CONST_IDX -> CONST_VAL.
  - in_sel < NUM_IN -> channel in_sel.
  - in_sel >= NUM_IN -> data 0 with err=1.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N when the output register is free or draining.
- Storage: main output register plus one skid register.
  - in_ready = !skid_full. It is registered and has no combinational path from out_ready.
- Per-edge cases:
  - Main empty or draining (out_ready=1), beat accepted -> beat loads into main.
  - Main full and stalled (out_ready=0), beat accepted -> beat loads into skid; skid_full=1, so in_ready=0 next cycle.
  - Skid full and main drains -> skid moves to main; skid empties and in_ready=1 next cycle.
  - Skid full: no new beat can be accepted, because in_ready=0.
  - Drain and accept in the same cycle with skid empty -> new beat replaces main; out_valid stays 1.
- Ordering: beats leave in acceptance order. No beat is dropped or duplicated.
- Stability: while out_valid && !out_ready, out_data, out_sel and out_err must not change.
- Reset mid-operation: any held beats are discarded and all outputs return to reset values immediately.

Optional Feature:
- Macro: ALU_OPERAND_SEL_ERRCNT_EN.
- When defined:
  - Adds output err_count (8 bits).
  - err_count increments on each accepted beat with in_sel >= NUM_IN and saturates at 255.
  - Adds input err_clr (1 bit), which clears err_count synchronously; clear wins over a simultaneous increment.
  - Reset value of err_count is 0.
- When undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Defaults, out_ready=1: channel 0=0x0000_0011, in_sel=0, then 1, 2, 3 on consecutive cycles (channel 2=0xFFFF_FFF0, channel 3=0x0000_0040) -> out_data one cycle later = 0x11, 0x4, 0xFFFF_FFF0, 0x40; out_valid continuous; out_err=0.
- Backpressure: out_ready=0, send beats A=0xA, B=0xB -> A held on out_data, B in skid, in_ready=0. Raise out_ready -> A then B emitted in order; in_ready=1 one cycle after skid drains.
- Out-of-range: NUM_IN=3, SEL_W=2, in_sel=3 -> out_data=0, out_err=1, out_sel=3. With ALU_OPERAND_SEL_ERRCNT_EN defined, err_count=1.
- Constant override: CONST_IDX=1, in_data channel 1 = 0xDEAD_BEEF -> out_data=0x0000_0004.
- Async reset: assert reset_n=0 mid-cycle with skid full -> out_valid=0, out_data=0, in_ready=1 without waiting for a clock edge; no stale beat after release.
- Counter saturation (macro defined): 300 out-of-range beats -> err_count=255. Pulse err_clr together with another bad beat -> err_count=0.
